// File: rtl/upsample2x.sv
// upsample2x: nearest-neighbour 2x2 upsampler between valid/ready streams, registered output stage.
// Macro UPSAMPLE2X_VDUP_EN builds the line buffer and REPLAY state; undefined gives horizontal-only 2x.
module upsample2x #(
   parameter int DW = 8,
   parameter int DN = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DN*DW-1:0] m_data,
   input  logic             m_valid,
   output logic             m_ready,
   input  logic [5:0]       m_width,
   input  logic             m_up_en,
   output logic [DN*DW-1:0] s_data,
   output logic             s_valid,
   input  logic             s_ready
);

   localparam int BW = DN * DW;

   typedef enum logic {FILL, REPLAY} state_e;

   state_e        state_q;
   logic          phase_q;
   logic [5:0]    col_q;
   logic [6:0]    width_q;
   logic [6:0]    width_d;
   logic [BW-1:0] hold_q;
   logic [BW-1:0] s_data_q;
   logic          s_valid_q;

   logic out_ok;
   logic first_beat;
   logic bypass;
   logic accept;
   logic last_col;

`ifdef UPSAMPLE2X_VDUP_EN
   logic [BW-1:0] buf_q [64];
`endif

   assign out_ok     = !s_valid_q || s_ready;
   // Mode is only decided at the first beat of a row; later m_up_en changes cannot reach the FSM.
   assign first_beat = (state_q == FILL) && (col_q == 6'd0) && !phase_q;
   assign bypass     = first_beat && !m_up_en;
   assign m_ready    = !rst && out_ok && (state_q == FILL) && !phase_q;
   assign accept     = m_valid && m_ready;
   assign last_col   = ({1'b0, col_q} == (width_q - 7'd1));
   assign width_d    = (m_width == 6'd0) ? 7'd64 : {1'b0, m_width};

   assign s_data  = s_data_q;
   assign s_valid = s_valid_q;

   // NOTE: sequential state uses only non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         phase_q   <= 1'b0;
         col_q     <= 6'd0;
         width_q   <= 7'd64;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
      end else if (out_ok) begin
         if ((state_q == FILL) && !phase_q) begin
            if (accept) begin
               s_data_q  <= m_data;
               s_valid_q <= 1'b1;
               if (!bypass) begin
                  hold_q  <= m_data;
                  phase_q <= 1'b1;
                  if (col_q == 6'd0) width_q <= width_d;
               end
            end else begin
               s_valid_q <= 1'b0;
            end
         end else if (state_q == FILL) begin
            s_data_q  <= hold_q;
            s_valid_q <= 1'b1;
            phase_q   <= 1'b0;
            if (last_col) begin
               col_q <= 6'd0;
`ifdef UPSAMPLE2X_VDUP_EN
               state_q <= REPLAY;
`endif
            end else begin
               col_q <= col_q + 6'd1;
            end
         end
`ifdef UPSAMPLE2X_VDUP_EN
         else begin
            s_data_q  <= buf_q[col_q];
            s_valid_q <= 1'b1;
            phase_q   <= !phase_q;
            if (phase_q) begin
               if (last_col) begin
                  col_q   <= 6'd0;
                  state_q <= FILL;
               end else begin
                  col_q <= col_q + 6'd1;
               end
            end
         end
`endif
      end
   end

`ifdef UPSAMPLE2X_VDUP_EN
   // NOTE: the line buffer is pure storage and has no reset; every entry is written before it is replayed.
   always_ff @(posedge clk) begin
      if (accept && !bypass) buf_q[col_q] <= m_data;
   end
`endif

endmodule

// File: tb/tb_upsample2x.sv
// tb_upsample2x: randomized scoreboard bench for upsample2x against a row-level reference model.
// Expected replay depends on whether UPSAMPLE2X_VDUP_EN is defined for the build.
module tb_upsample2x;

   localparam int DW = 8;
   localparam int DN = 6;
   localparam int BW = DN * DW;
`ifdef UPSAMPLE2X_VDUP_EN
   localparam bit VDUP = 1'b1;
`else
   localparam bit VDUP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [5:0]    m_width;
   logic          m_up_en;
   logic [BW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;

   upsample2x #(.DW(DW), .DN(DN)) dut (
      .clk     (clk),
      .rst     (rst),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_width (m_width),
      .m_up_en (m_up_en),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] data;
      int            acc_cyc;
      bit            lat;
   } exp_t;

   exp_t          exp_q[$];
   int            out_cycs[$];
   logic [BW-1:0] row_q[$];
   int            row_cnt = 0;
   int            row_w   = 64;
   bit            row_up  = 1'b1;
   int            total   = 0;
   int            bad     = 0;
   int            cyc     = 0;
   int            sr_mode = 0;   // 0: always ready, 1: toggle, 2: random
   bit            lat_mode = 1'b0;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [BW-1:0] rnd();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[BW-1:0];
   endfunction

   function automatic void push_exp(input logic [BW-1:0] d);
      exp_t e;
      e.data    = d;
      e.acc_cyc = cyc;
      e.lat     = lat_mode;
      exp_q.push_back(e);
   endfunction

   // Reference: a row is framed by the width seen on its first beat; upsampled rows emit every
   // pixel twice, then (with vertical duplication) the whole doubled row once more.
   function automatic void model_accept(input logic [BW-1:0] d, input logic up, input logic [5:0] w);
      if (row_cnt == 0) begin
         row_up = up;
         row_w  = (w == 6'd0) ? 64 : int'(w);
      end
      if (!row_up) begin
         push_exp(d);
      end else begin
         push_exp(d);
         push_exp(d);
         row_q.push_back(d);
         row_cnt++;
         if (row_cnt == row_w) begin
            if (VDUP) begin
               foreach (row_q[i]) begin
                  push_exp(row_q[i]);
                  push_exp(row_q[i]);
               end
            end
            row_q.delete();
            row_cnt = 0;
         end
      end
   endfunction

   task automatic send(input logic [BW-1:0] d, input logic up, input logic [5:0] w, output int waited);
      bit acc;
      acc    = 1'b0;
      waited = 0;
      @(negedge clk);
      m_data  = d;
      m_valid = 1'b1;
      m_up_en = up;
      m_width = w;
      forever begin
         #1 acc = m_ready;
         @(posedge clk);
         if (acc) break;
         waited++;
         if (waited > 2000) begin
            check(1'b0, "accept_timeout", 64'(waited), 64'd0);
            break;
         end
         @(negedge clk);
      end
      if (acc) model_accept(d, up, w);
   endtask

   task automatic send1(input logic [BW-1:0] d, input logic up, input logic [5:0] w);
      int dummy;
      send(d, up, w, dummy);
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      m_valid = 1'b0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(exp_q.size() == 0, "drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
      end
   end

   initial begin
      s_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (sr_mode)
            0:       s_ready = 1'b1;
            1:       s_ready = !s_ready;
            default: s_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops one expectation per output handshake and checks stall stability.
   initial begin
      exp_t          e;
      bit            stalled;
      logic [BW-1:0] stall_data;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            check(s_valid && (s_data == stall_data), "stall_hold", 64'(s_data), 64'(stall_data));
         end
         if (s_valid && s_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_out", 64'(s_data), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check(s_data == e.data, "out_data", 64'(s_data), 64'(e.data));
               if (e.lat) check(cyc == e.acc_cyc + 1, "bypass_latency", 64'(cyc), 64'(e.acc_cyc + 1));
            end
            out_cycs.push_back(cyc);
         end
         stalled    = s_valid && !s_ready;
         stall_data = s_data;
      end
   end

   initial begin
      int            waited;
      int            n;
      logic [BW-1:0] a;
      logic [BW-1:0] b;

      rst     = 1'b1;
      m_valid = 1'b1;
      m_data  = rnd() | 48'h1;
      m_up_en = 1'b1;
      m_width = 6'd3;

      // Reset held two cycles with m_valid high
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check(s_valid == 1'b0, "rst_s_valid", 64'(s_valid), 64'd0);
         check(s_data == '0, "rst_s_data", 64'(s_data), 64'd0);
         check(m_ready == 1'b0, "rst_m_ready", 64'(m_ready), 64'd0);
      end
      rst     = 1'b0;
      m_valid = 1'b0;
      #1;
      check(m_ready == 1'b1, "m_ready_after_rst", 64'(m_ready), 64'd1);

      // Width 3 row, then a single-beat row whose accept waits out the replay
      out_cycs.delete();
      send1(rnd(), 1'b1, 6'd3);
      send1(rnd(), 1'b1, 6'd3);
      send1(rnd(), 1'b1, 6'd3);
      send(rnd(), 1'b1, 6'd1, waited);
      check(waited == (VDUP ? 7 : 1), "m_ready_low_cycles", 64'(waited), 64'(VDUP ? 7 : 1));
      drain();
      n = VDUP ? 12 : 6;
      check(out_cycs.size() == n + (VDUP ? 4 : 2), "w3_out_count", 64'(out_cycs.size()), 64'(n + (VDUP ? 4 : 2)));
      if (out_cycs.size() >= n)
         check(out_cycs[n-1] - out_cycs[0] == n - 1, "w3_consecutive", 64'(out_cycs[n-1] - out_cycs[0]), 64'(n - 1));

      // Width 0 means 64; col wraps and FILL resumes for a following row
      out_cycs.delete();
      for (int i = 0; i < 64; i++) send1(BW'(i), 1'b1, 6'd0);
      drain();
      n = VDUP ? 256 : 128;
      check(out_cycs.size() == n, "w64_out_count", 64'(out_cycs.size()), 64'(n));
      if (out_cycs.size() == n)
         check(out_cycs[n-1] - out_cycs[0] == n - 1, "w64_consecutive", 64'(out_cycs[n-1] - out_cycs[0]), 64'(n - 1));
      send1(rnd(), 1'b1, 6'd2);
      send1(rnd(), 1'b1, 6'd2);
      drain();

      // Backpressure with s_ready toggling
      sr_mode = 1;
      out_cycs.delete();
      a = rnd();
      b = rnd();
      send1(a, 1'b1, 6'd2);
      send1(b, 1'b1, 6'd2);
      drain();
      check(out_cycs.size() == (VDUP ? 8 : 4), "bp_out_count", 64'(out_cycs.size()), 64'(VDUP ? 8 : 4));

      // Bypass: five beats, each out one cycle after accept
      sr_mode  = 0;
      lat_mode = 1'b1;
      out_cycs.delete();
      for (int i = 0; i < 5; i++) send1(rnd(), 1'b0, 6'd3);
      drain();
      lat_mode = 1'b0;
      check(out_cycs.size() == 5, "bypass_out_count", 64'(out_cycs.size()), 64'd5);

      // m_up_en dropped at col 1: ignored for this row pair, next row bypassed
      send1(rnd(), 1'b1, 6'd4);
      for (int i = 0; i < 3; i++) send1(rnd(), 1'b0, 6'd4);
      drain();
      lat_mode = 1'b1;
      send1(rnd(), 1'b0, 6'd4);
      send1(rnd(), 1'b0, 6'd4);
      drain();
      lat_mode = 1'b0;

      // Reset mid-row discards the partial row
      sr_mode = 2;
      send1(rnd(), 1'b1, 6'd5);
      send1(rnd(), 1'b1, 6'd5);
      @(negedge clk);
      rst     = 1'b1;
      m_valid = 1'b0;
      @(posedge clk);
      exp_q.delete();
      row_q.delete();
      row_cnt = 0;
      @(negedge clk);
      #1;
      check(m_ready == 1'b0, "midrow_rst_m_ready", 64'(m_ready), 64'd0);
      check(s_valid == 1'b0, "midrow_rst_s_valid", 64'(s_valid), 64'd0);
      rst = 1'b0;
      sr_mode = 0;
      send1(rnd(), 1'b1, 6'd2);
      send1(rnd(), 1'b1, 6'd2);
      drain();

      // Randomized traffic: widths, modes, gaps and backpressure
      sr_mode = 2;
      for (int i = 0; i < 400; i++) begin
         send1(rnd(), ($urandom_range(0, 3) != 0), 6'($urandom_range(1, 6)));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            m_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
